// File: rtl/inst_prefetch.sv
`default_nettype none
// inst_prefetch: issues sequential word reads to a synchronous ROM and buffers the
// returned {pc, inst} pairs in a small FIFO for decode; a redirect flushes and restarts.
module inst_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic          r_kill;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_credit;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_pc_lsb;

  // An outstanding read reserves a slot, so a returning response always fits.
  assign w_credit = r_count + CW'(r_inflight);
  assign w_issue  = rst && !redirect_i && (w_credit < C_DEPTH);
  assign w_push   = r_inflight && !r_kill && !redirect_i;
  assign w_pop    = inst_valid_o && inst_ready_i && !redirect_i;

  assign w_unused_pc_lsb = &{1'b0, redirect_pc_i[1:0]};

  assign rom_ce_o     = w_issue;
  assign rom_addr_o   = r_fetch_pc;
  assign inst_valid_o = (r_count != '0);
  assign inst_o       = r_mem_inst[r_rd_ptr];
  assign inst_pc_o    = r_mem_pc[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_kill        <= 1'b0;
    end else if (redirect_i) begin
      r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= 1'b0;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_inst[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
      r_mem_inst[r_wr_ptr] <= rom_data_i;
    end
  end

endmodule
`default_nettype wire
